// File: rtl/sqrt_share_ctrl_if.sv
// Bundle between the sqrt scheduler, its requesters and the shared root unit.
// The slave modport is the scheduler's view; master is the environment side.
interface sqrt_share_ctrl_if #(
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]    req;
   logic [32*NREQ-1:0] x_in;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic [15:0]        y_out;
   logic               err;
   logic               sq_reset;
   logic [31:0]        sq_x;
   logic               sq_rdy;
   logic [15:0]        sq_y;

   modport master (
      output req, x_in, sq_rdy, sq_y,
      input  grant, done, y_out, err, sq_reset, sq_x
   );

   modport slave (
      input  req, x_in, sq_rdy, sq_y,
      output grant, done, y_out, err, sq_reset, sq_x
   );
endinterface

// File: rtl/sqrt_share_ctrl.sv
// Round-robin scheduler sharing one iterative sqrt32 root unit among NREQ
// requesters, with a watchdog that aborts operations whose rdy never comes.
module sqrt_share_ctrl #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   sqrt_share_ctrl_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   ptr, ptr_nx;
   logic [IW-1:0]   idx, idx_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [NREQ-1:0] grant, grant_nx;
   logic [NREQ-1:0] done, done_nx;
   logic            err, err_nx;
   logic [15:0]     y, y_nx;
   logic [31:0]     sqx, sqx_nx;
   logic            sqr, sqr_nx;

   logic            found;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   rr_c;
   logic [31:0]     x_sel;
   logic            tmo;
   logic [NREQ-1:0] pick_oh;
   logic [NREQ-1:0] idx_oh;

   // Search upward from ptr with wrap; the first asserted req wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      rr_c  = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_c = IW'((int'(ptr) + k) % NREQ);
         if (!found && bus.req[rr_c]) begin
            found = 1'b1;
            pick  = rr_c;
         end
      end
   end

   always_comb begin
      x_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IW'(i)) x_sel = bus.x_in[32*i +: 32];
      end
   end

   assign tmo     = (cnt == CW'(TIMEOUT - 1));
   assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
   assign idx_oh  = {{(NREQ-1){1'b0}}, 1'b1} << idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         cnt   <= '0;
         grant <= '0;
         done  <= '0;
         err   <= 1'b0;
         y     <= '0;
         sqx   <= '0;
         sqr   <= 1'b1;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         grant <= grant_nx;
         done  <= done_nx;
         err   <= err_nx;
         y     <= y_nx;
         sqx   <= sqx_nx;
         sqr   <= sqr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (found) state_nx = LAUNCH;
         LAUNCH:  state_nx = BUSY;
         BUSY:    if (bus.sq_rdy || tmo) state_nx = RELEASE;
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // sq_rdy is only looked at in BUSY, so a stale flag elsewhere is harmless.
   always_comb begin
      ptr_nx   = ptr;
      idx_nx   = idx;
      cnt_nx   = cnt;
      grant_nx = grant;
      done_nx  = done;
      err_nx   = err;
      y_nx     = y;
      sqx_nx   = sqx;
      sqr_nx   = sqr;
      case (state)
         IDLE: begin
            sqr_nx = 1'b1;
            if (found) begin
               idx_nx   = pick;
               grant_nx = pick_oh;
               sqx_nx   = x_sel;
            end
         end
         LAUNCH: begin
            sqr_nx = 1'b0;
            cnt_nx = '0;
         end
         BUSY: begin
            cnt_nx = cnt + 1'b1;
            if (bus.sq_rdy) begin
               y_nx    = bus.sq_y;
               done_nx = idx_oh;
               sqr_nx  = 1'b1;
            end else if (tmo) begin
               y_nx    = 16'hFFFF;
               done_nx = idx_oh;
               err_nx  = 1'b1;
               sqr_nx  = 1'b1;
            end
         end
         RELEASE: begin
            grant_nx = '0;
            done_nx  = '0;
            err_nx   = 1'b0;
            ptr_nx   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.grant    = grant;
   assign bus.done     = done;
   assign bus.err      = err;
   assign bus.y_out    = y;
   assign bus.sq_x     = sqx;
   assign bus.sq_reset = sqr;
endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Scoreboard bench for sqrt_share_ctrl: a behavioural root unit answers with
// floor(sqrt(sq_x)) after a programmable delay; expected results are constants.
module tb_sqrt_share_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sqrt_share_ctrl_if #(.NREQ(4)) bus ();

   sqrt_share_ctrl #(.NREQ(4), .TIMEOUT(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          idx;
      logic [15:0] y;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   int          rdy_delay = -1;
   logic        stale_rdy = 1'b0;
   logic        model_rdy = 1'b0;
   logic [15:0] model_y   = 16'h0;
   int          mcnt      = 0;

   assign bus.sq_rdy = model_rdy | stale_rdy;
   assign bus.sq_y   = model_y;

   function automatic logic [15:0] isqrt(input logic [31:0] x);
      longint r = 0;
      while ((r + 1) * (r + 1) <= longint'(x)) r++;
      return r[15:0];
   endfunction

   // Root unit: held in reset while sq_reset is high, answers after rdy_delay cycles.
   always @(posedge clk) begin
      if (bus.sq_reset) begin
         mcnt      <= 0;
         model_rdy <= 1'b0;
      end else begin
         mcnt <= mcnt + 1;
         if (rdy_delay >= 0 && mcnt + 1 >= rdy_delay) begin
            model_rdy <= 1'b1;
            model_y   <= isqrt(bus.sq_x);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic expect_op(input int idx, input logic [15:0] y, input logic err, input int lat);
      exp_t e;
      e.idx = idx; e.y = y; e.err = err; e.lat = lat;
      sbq.push_back(e);
   endtask

   task automatic wait_done(output logic [3:0] d);
      int n;
      n = 0;
      d = '0;
      while (n < 200 && d == 0) begin
         @(negedge clk);
         n++;
         d = bus.done;
      end
      chk("done_seen", 32'(d != 0), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      bus.req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic monitor();
      int          lowcnt;
      bit          post;
      exp_t        e;
      logic [3:0]  one;
      lowcnt = 0;
      post   = 0;
      one    = 4'b0001;
      forever begin
         @(negedge clk);
         chk("inv_onehot", 32'($onehot0(bus.grant)), 1);
         chk("inv_done_in_grant", 32'((bus.done & ~bus.grant) == 0), 1);
         chk("inv_err_implies_done", 32'(!bus.err || bus.done != 0), 1);
         if (post) begin
            chk("grant_after_done", 32'(bus.grant), 0);
            chk("done_one_cycle", 32'(bus.done), 0);
            post = 0;
         end
         if (bus.done != 0) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'(bus.done), 0);
            end else begin
               e = sbq.pop_front();
               chk("done_idx", 32'(bus.done), 32'(one << e.idx));
               chk("done_grant", 32'(bus.grant), 32'(one << e.idx));
               chk("y_out", 32'(bus.y_out), 32'(e.y));
               chk("err", 32'(bus.err), 32'(e.err));
               if (e.lat >= 0) chk("busy_latency", lowcnt, e.lat);
            end
            post = 1;
         end
         if (bus.sq_reset) lowcnt = 0;
         else lowcnt++;
      end
   endtask

   initial begin
      logic [3:0] d;
      bit         stale_ok;
      bus.req  = '0;
      bus.x_in = '0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_y_out", 32'(bus.y_out), 0);
      chk("rst_sq_x", bus.sq_x, 0);
      chk("rst_sq_reset", 32'(bus.sq_reset), 1);
      reset = 1'b0;

      // Test 1: single request, latency and late operand change
      @(negedge clk);
      rdy_delay = 20;
      bus.x_in[31:0] = 32'd63;
      expect_op(0, 16'd7, 1'b0, 21);
      bus.req = 4'b0001;
      @(negedge clk);
      chk("t1_grant", 32'(bus.grant), 32'h1);
      chk("t1_sq_x", bus.sq_x, 32'd63);
      chk("t1_launch_sq_reset", 32'(bus.sq_reset), 1);
      bus.x_in[31:0] = 32'd0;
      @(negedge clk);
      chk("t1_busy_sq_reset", 32'(bus.sq_reset), 0);
      chk("t1_sq_x_held", bus.sq_x, 32'd63);
      wait_done(d);
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("t1_y_hold", 32'(bus.y_out), 32'd7);

      // Test 2: all four requesting from reset
      @(negedge clk);
      reset     = 1'b1;
      rdy_delay = 4;
      bus.x_in  = {32'd4, 32'd100, 32'd81, 32'd16};
      bus.req   = 4'b1111;
      expect_op(0, 16'd4, 1'b0, 5);
      expect_op(1, 16'd9, 1'b0, 5);
      expect_op(2, 16'd10, 1'b0, 5);
      expect_op(3, 16'd2, 1'b0, 5);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_done(d);
         bus.req = bus.req & ~d;
      end
      repeat (3) @(negedge clk);

      // Test 3: req0 held, req2 re-raised after each completion
      do_reset();
      rdy_delay = 3;
      bus.x_in  = {32'd0, 32'd144, 32'd0, 32'd25};
      expect_op(0, 16'd5, 1'b0, 4);
      expect_op(2, 16'd12, 1'b0, 4);
      expect_op(0, 16'd5, 1'b0, 4);
      expect_op(2, 16'd12, 1'b0, 4);
      bus.req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         wait_done(d);
         if (i == 3) begin
            bus.req = '0;
         end else if (d[2]) begin
            bus.req[2] = 1'b0;
            @(negedge clk);
            bus.req[2] = 1'b1;
         end
      end
      repeat (3) @(negedge clk);

      // Test 4: watchdog abort, then the pending requester is served
      do_reset();
      rdy_delay = -1;
      bus.x_in  = {32'd0, 32'd0, 32'd49, 32'd1000};
      expect_op(0, 16'hFFFF, 1'b1, 64);
      expect_op(1, 16'd7, 1'b0, 6);
      bus.req = 4'b0011;
      wait_done(d);
      chk("t4_sq_reset_back", 32'(bus.sq_reset), 1);
      bus.req[0] = 1'b0;
      rdy_delay  = 5;
      wait_done(d);
      bus.req = '0;
      repeat (3) @(negedge clk);

      // Test 5: rdy on the timeout cycle wins; one cycle later it is too late
      do_reset();
      rdy_delay = 63;
      bus.x_in  = {32'd0, 32'd0, 32'd0, 32'd200};
      expect_op(0, 16'd14, 1'b0, 64);
      bus.req = 4'b0001;
      wait_done(d);
      bus.req = '0;
      repeat (2) @(negedge clk);
      rdy_delay = 64;
      expect_op(0, 16'hFFFF, 1'b1, 64);
      bus.req = 4'b0001;
      wait_done(d);
      bus.req = '0;
      repeat (3) @(negedge clk);

      // Test 6: asynchronous reset mid-BUSY with ptr advanced beforehand
      do_reset();
      rdy_delay = 4;
      bus.x_in  = {32'd0, 32'd9, 32'd36, 32'd16};
      expect_op(1, 16'd6, 1'b0, 5);
      bus.req = 4'b0010;
      wait_done(d);
      bus.req = '0;
      repeat (2) @(negedge clk);
      rdy_delay = -1;
      bus.req   = 4'b0100;
      repeat (10) @(negedge clk);
      chk("t6_busy_grant", 32'(bus.grant), 32'h4);
      #2;
      reset   = 1'b1;
      bus.req = '0;
      #1;
      chk("t6_async_grant", 32'(bus.grant), 0);
      chk("t6_async_sq_reset", 32'(bus.sq_reset), 1);
      @(negedge clk);
      reset     = 1'b0;
      stale_rdy = 1'b1;
      stale_ok  = 1;
      repeat (5) begin
         @(negedge clk);
         if (bus.done != 0 || bus.grant != 0) stale_ok = 0;
      end
      chk("t6_stale_rdy_ignored", 32'(stale_ok), 1);
      stale_rdy = 1'b0;
      rdy_delay = 2;
      expect_op(0, 16'd4, 1'b0, 3);
      expect_op(2, 16'd3, 1'b0, 3);
      bus.req = 4'b0101;
      wait_done(d);
      bus.req[0] = 1'b0;
      wait_done(d);
      bus.req = '0;
      repeat (5) @(negedge clk);

      chk("scoreboard_empty", 32'(sbq.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
